// File: rtl/aq_lsu_spsram_128x8_ctrl_if.sv
// Request/response channel between the LSU and the 128x8 SRAM access
// controller.
//   req_*  : single-beat read/write request (valid/ready handshake)
//   rsp_*  : read data return (valid/ready handshake)
// master = requester (LSU side), slave = controller.
interface aq_lsu_spsram_128x8_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  req_vld;
  logic                  req_rdy;
  logic                  req_wr;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic [DATA_WIDTH-1:0] req_wmask;
  logic                  rsp_vld;
  logic                  rsp_rdy;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  modport master (
    output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata
  );

  modport slave (
    input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata
  );
endinterface

// File: rtl/aq_lsu_spsram_128x8_ctrl.sv
// Access controller in front of the 128x8 single-port SRAM wrapper.
// After reset (or on ctrl_init_req) it writes INIT_VALUE to every entry,
// then serves single-beat reads/writes. Read data returns one cycle after
// acceptance; a one-entry buffer holds it while the consumer stalls.
// Ports:
//   forever_cpuclk, cpurst_b : clock, async active-low reset
//   ctrl_init_req            : pulse, re-clear the whole array
//   ctrl_init_busy           : high while clearing (RST/INIT)
//   acc                      : request/response channel (slave side)
//   sram_cen/gwen/wen/a/d    : SRAM pins (all active-low controls)
//   sram_q                   : SRAM read data, valid cycle after a read
module aq_lsu_spsram_128x8_ctrl #(
  parameter int unsigned          ADDR_WIDTH = 7,
  parameter int unsigned          DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  ctrl_init_req,
  output logic                  ctrl_init_busy,
  aq_lsu_spsram_128x8_ctrl_if.slave acc,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_INIT = 2'd1,
    ST_IDLE = 2'd2
  } state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  rd_pend;
  logic                  buf_vld;
  logic [DATA_WIDTH-1:0] rsp_buf;
  logic                  rsp_vld;
  logic                  req_rdy;
  logic                  accept;

  assign rsp_vld     = rd_pend | buf_vld;
  // A stalled response blocks all new requests, so rd_pend and buf_vld
  // can never be set together.
  assign req_rdy     = (state == ST_IDLE) & ~ctrl_init_req & ~(rsp_vld & ~acc.rsp_rdy);
  assign accept      = acc.req_vld & req_rdy;
  assign acc.req_rdy = req_rdy;
  assign acc.rsp_vld = rsp_vld;
  assign ctrl_init_busy = (state != ST_IDLE);

  always_comb begin
    acc.rsp_rdata = '0;
    if (buf_vld)      acc.rsp_rdata = rsp_buf;
    else if (rd_pend) acc.rsp_rdata = sram_q;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state <= ST_RST;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_RST: begin
        state_nxt = ST_INIT;
        cnt_nxt   = '0;
      end
      ST_INIT: begin
        // Counter wraps to 0 on the last entry, ready for the next clear.
        cnt_nxt = cnt + 1'b1;
        if (cnt == '1) state_nxt = ST_IDLE;
      end
      ST_IDLE: begin
        if (ctrl_init_req && !rsp_vld) begin
          state_nxt = ST_INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = ST_RST;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_a    = '0;
    sram_d    = '0;
    if (state == ST_INIT) begin
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
      sram_a    = cnt;
      sram_d    = INIT_VALUE;
    end else if (accept) begin
      sram_cen = 1'b0;
      sram_a   = acc.req_addr;
      if (acc.req_wr) begin
        sram_gwen = 1'b0;
        sram_wen  = ~acc.req_wmask;
        sram_d    = acc.req_wdata;
      end
    end
  end

  // SRAM Q is only valid for one cycle; capture it if the consumer
  // is not ready in that cycle.
  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_pend <= 1'b0;
      buf_vld <= 1'b0;
      rsp_buf <= '0;
    end else begin
      rd_pend <= accept & ~acc.req_wr;
      if (rd_pend && !acc.rsp_rdy) begin
        buf_vld <= 1'b1;
        rsp_buf <= sram_q;
      end else if (buf_vld && acc.rsp_rdy) begin
        buf_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aq_lsu_spsram_128x8_ctrl.sv
// Directed bench for aq_lsu_spsram_128x8_ctrl with a behavioural 128x8
// SRAM attached to its pins.
module tb_aq_lsu_spsram_128x8_ctrl;

  logic       clk;
  logic       rst_n;
  logic       init_req;
  logic       busy;
  logic       sram_cen;
  logic       sram_gwen;
  logic [7:0] sram_wen;
  logic [6:0] sram_a;
  logic [7:0] sram_d;
  logic [7:0] sram_q;
  logic [7:0] mem [128];

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  aq_lsu_spsram_128x8_ctrl_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();

  aq_lsu_spsram_128x8_ctrl #(
    .ADDR_WIDTH (7),
    .DATA_WIDTH (8),
    .INIT_VALUE (8'h00)
  ) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_n),
    .ctrl_init_req  (init_req),
    .ctrl_init_busy (busy),
    .acc            (bus),
    .sram_cen       (sram_cen),
    .sram_gwen      (sram_gwen),
    .sram_wen       (sram_wen),
    .sram_a         (sram_a),
    .sram_d         (sram_d),
    .sram_q         (sram_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: contents start as junk, Q is junk except the cycle after a read.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 128; i++) mem[i] <= 8'h5A ^ 8'(i);
      sram_q <= 8'hC3;
    end else begin
      if (!sram_cen && !sram_gwen)
        mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      if (!sram_cen && sram_gwen) sram_q <= mem[sram_a];
      else                        sram_q <= 8'hC3;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Walk init cycles 0..last, checking one SRAM write per cycle.
  task automatic init_walk(input string tag, input int last);
    for (int k = 0; k <= last; k++) begin
      @(negedge clk); #1;
      chk({tag, " addr"}, 32'(sram_a), 32'(k));
      chk({tag, " pins"},
          {sram_cen, sram_gwen, sram_wen, sram_d, busy, bus.req_rdy, bus.rsp_vld},
          {1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0});
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " ctl"}, {bus.req_rdy, bus.rsp_vld, bus.rsp_rdata, busy},
        {1'b0, 1'b0, 8'h00, 1'b1});
    chk({tag, " sram"}, {sram_cen, sram_gwen, sram_wen, sram_a, sram_d},
        {1'b1, 1'b1, 8'hFF, 7'h00, 8'h00});
  endtask

  typedef struct packed {
    logic       vld;
    logic       wr;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] wmask;
    logic       rrdy;
    logic       e_rdy;
    logic       e_rvld;
    logic [7:0] e_rdata;
    logic       e_cen;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  initial begin
    // Read responses show up in the row after the read.
    //           vld   wr    addr   wdata  wmask  rrdy  e_rdy e_rvld e_rdata e_cen
    vecs[0]  = '{1'b1, 1'b0, 7'h55, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 7'h03, 8'hA5, 8'hFF, 1'b1, 1'b1, 1'b1, 8'h00, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 7'h03, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 7'h0A, 8'hFF, 8'h0F, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 7'h0A, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 7'h0A, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 7'h0A, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 7'h03, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 7'h0A, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 7'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 1'b1, 8'h0F, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 7'h7F, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 7'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h80, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 7'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 8'h00, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 7'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1};

    rst_n = 1'b0;
    init_req = 1'b0;
    bus.req_vld = 1'b0;
    bus.req_wr = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.req_wmask = '0;
    bus.rsp_rdy = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk_reset("reset");

    // Power-up clear
    @(negedge clk);
    rst_n = 1'b1;
    init_walk("init0", 127);
    @(negedge clk); #1;
    chk("init0 done", {busy, bus.req_rdy}, {1'b0, 1'b1});

    // Table of single-beat transactions
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      bus.req_vld   = vecs[i].vld;
      bus.req_wr    = vecs[i].wr;
      bus.req_addr  = vecs[i].addr;
      bus.req_wdata = vecs[i].wdata;
      bus.req_wmask = vecs[i].wmask;
      bus.rsp_rdy   = vecs[i].rrdy;
      #1;
      chk($sformatf("vec%0d", i),
          {bus.req_rdy, bus.rsp_vld, bus.rsp_rdata, sram_cen},
          {vecs[i].e_rdy, vecs[i].e_rvld, vecs[i].e_rdata, vecs[i].e_cen});
    end

    // Stalled response: read addr 3, consumer not ready for 4 cycles
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 7'h03; bus.rsp_rdy = 1'b0;
    #1;
    chk("stall accept", 32'(bus.req_rdy), 32'd1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.req_vld = 1'b1; bus.req_addr = 7'h0A;
      #1;
      chk($sformatf("stall hold%0d", i),
          {bus.rsp_vld, bus.rsp_rdata, bus.req_rdy, sram_cen},
          {1'b1, 8'hA5, 1'b0, 1'b1});
    end
    @(negedge clk);
    bus.req_vld = 1'b0; bus.rsp_rdy = 1'b1;
    #1;
    chk("stall drain", {bus.rsp_vld, bus.rsp_rdata, bus.req_rdy}, {1'b1, 8'hA5, 1'b1});
    @(negedge clk); #1;
    chk("stall after", {bus.rsp_vld, bus.rsp_rdata, bus.req_rdy}, {1'b0, 8'h00, 1'b1});

    // Re-init via pulse; request held valid throughout must be ignored
    @(negedge clk);
    init_req = 1'b1;
    bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 7'h05;
    #1;
    chk("reinit pulse", {bus.req_rdy, sram_cen, busy}, {1'b0, 1'b1, 1'b0});
    @(posedge clk); #1;
    init_req = 1'b0;
    init_walk("reinit", 127);
    @(negedge clk);
    bus.req_vld = 1'b0;
    #1;
    chk("reinit done", {busy, bus.req_rdy}, {1'b0, 1'b1});

    // Back-to-back readback of the whole array
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      bus.req_vld = 1'b1; bus.req_wr = 1'b0; bus.req_addr = 7'(i);
      #1;
      chk($sformatf("rb rdy%0d", i), 32'(bus.req_rdy), 32'd1);
      if (i > 0)
        chk($sformatf("rb data%0d", i - 1), {bus.rsp_vld, bus.rsp_rdata}, {1'b1, 8'h00});
    end
    @(negedge clk);
    bus.req_vld = 1'b0;
    #1;
    chk("rb data127", {bus.rsp_vld, bus.rsp_rdata}, {1'b1, 8'h00});

    // Reset while a response is stalled
    @(negedge clk);
    bus.req_vld = 1'b1; bus.req_addr = 7'h03; bus.rsp_rdy = 1'b0;
    @(negedge clk);
    bus.req_vld = 1'b0;
    #1;
    chk("pend before rst", 32'(bus.rsp_vld), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset("rst mid rsp");
    @(negedge clk);
    rst_n = 1'b1;
    bus.rsp_rdy = 1'b1;

    // Reset at init cnt=60, then a full restart from address 0
    init_walk("part", 60);
    rst_n = 1'b0;
    #1;
    chk_reset("rst mid init");
    @(negedge clk);
    rst_n = 1'b1;
    init_walk("restart", 127);
    @(negedge clk); #1;
    chk("restart done", {busy, bus.req_rdy, bus.rsp_vld}, {1'b0, 1'b1, 1'b0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
